// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller.
// Optional feature macro: BTB_CNT2_EN (2-bit saturating counters).
package btb_pkg;

    localparam int BTB_ENTRIES = 256;
    localparam int BTB_IDX_W   = 8;
    localparam int BTB_TAG_W   = 4;
    localparam int PC_W        = 14;
    localparam int TARGET_W    = 32;
    localparam int CTR_W       = 2;

    // Last index swept by an invalidate.
    localparam logic [BTB_IDX_W-1:0] IDX_LAST = BTB_IDX_W'(BTB_ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_FLUSH  = 2'd2
    } btb_state_e;

    // One resolved branch waiting to be written into the BTB.
    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [TARGET_W-1:0] target;
        logic                taken;
    } upd_entry_t;

    // Saturating 2-bit counter step.
    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] old,
                                                   input logic            taken);
        logic [CTR_W-1:0] nxt;
        if (taken) nxt = (old == 2'b11) ? old : old + 2'd1;
        else       nxt = (old == 2'b00) ? old : old - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue: synchronous FIFO with async reset, occupancy count and a
// clear that wins over a same-cycle push. Head entry is readable combinationally.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  upd_entry_t               din,
    output upd_entry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    upd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow so the pointers can never slip.
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear drops everything, incl. a same-cycle push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; reset keeps the head (and counter read index) at zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved branches, writes them into the BTB
// one per cycle, and sweeps all 256 entries to zero on an invalidate request.
// Optional feature macro: BTB_CNT2_EN (saturating counters with forwarding);
// without it the counter is written as taken ? 3 : 0.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        upd_valid_i,
    output logic                        upd_ready_o,
    input  logic [PC_W-1:0]             upd_pc_i,
    input  logic [TARGET_W-1:0]         upd_target_i,
    input  logic                        upd_taken_i,
    input  logic                        flush_req_i,
    output logic                        flush_busy_o,
    output logic [BTB_IDX_W-1:0]        ctr_rd_idx_o,
    input  logic [CTR_W-1:0]            ctr_rd_i,
    output logic                        btb_we_o,
    output logic [BTB_IDX_W-1:0]        btb_idx_o,
    output logic [BTB_TAG_W-1:0]        btb_tag_o,
    output logic [TARGET_W-1:0]         btb_target_o,
    output logic                        btb_valid_o,
    output logic [CTR_W-1:0]            btb_ctr_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

    btb_state_e       state;
    logic             flush_pend;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             go_flush;
    upd_entry_t       din;
    upd_entry_t       head;
    logic [BTB_IDX_W-1:0] head_idx;
    logic [BTB_TAG_W-1:0] head_tag;
    logic [CTR_W-1:0]     new_ctr;
    logic                 unused_pc_lsb;

    assign upd_ready_o = !fifo_full && (state != ST_FLUSH);
    assign push        = upd_valid_i && upd_ready_o;
    // A pending invalidate takes priority over queued updates.
    assign go_flush    = (state != ST_FLUSH) && flush_pend;
    assign pop         = (state != ST_FLUSH) && !flush_pend && !fifo_empty;

    assign din.pc      = upd_pc_i;
    assign din.target  = upd_target_i;
    assign din.taken   = upd_taken_i;

    assign head_idx      = head.pc[9:2];
    assign head_tag      = head.pc[13:10];
    assign ctr_rd_idx_o  = head_idx;
    assign unused_pc_lsb = ^head.pc[1:0];

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .clear  (go_flush),
        .din    (din),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .cnt    (fifo_cnt_o)
    );

`ifdef BTB_CNT2_EN
    logic [CTR_W-1:0] old_ctr;

    // Old counter: the BTB array lags one write, so take the in-flight write when it hits the same index.
    always_comb begin
        old_ctr = ctr_rd_i;
        if (btb_we_o && (btb_idx_o == head_idx)) old_ctr = btb_ctr_o;
        new_ctr = ctr_step(old_ctr, head.taken);
    end
`else
    logic unused_ctr_rd;
    assign unused_ctr_rd = ^ctr_rd_i;

    // Counter forced to strong taken / strong not-taken.
    always_comb begin
        new_ctr = head.taken ? 2'b11 : 2'b00;
    end
`endif

    // Control FSM with registered BTB write port; the write index doubles as the sweep counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            flush_pend   <= 1'b0;
            flush_busy_o <= 1'b0;
            btb_we_o     <= 1'b0;
            btb_idx_o    <= '0;
            btb_tag_o    <= '0;
            btb_target_o <= '0;
            btb_valid_o  <= 1'b0;
            btb_ctr_o    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_UPDATE: begin
                    if (go_flush) begin
                        // The write visible this cycle retires now; the sweep starts at index 0.
                        state        <= ST_FLUSH;
                        flush_pend   <= 1'b0;
                        flush_busy_o <= 1'b1;
                        btb_we_o     <= 1'b1;
                        btb_idx_o    <= '0;
                        btb_tag_o    <= '0;
                        btb_target_o <= '0;
                        btb_valid_o  <= 1'b0;
                        btb_ctr_o    <= '0;
                    end else begin
                        flush_pend <= flush_req_i;
                        btb_we_o   <= pop;
                        if (pop) begin
                            state        <= ST_UPDATE;
                            btb_idx_o    <= head_idx;
                            btb_tag_o    <= head_tag;
                            btb_target_o <= head.target;
                            btb_valid_o  <= 1'b1;
                            btb_ctr_o    <= new_ctr;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Requests arriving mid-sweep are dropped.
                    if (btb_idx_o == IDX_LAST) begin
                        state        <= ST_IDLE;
                        flush_busy_o <= 1'b0;
                        btb_we_o     <= 1'b0;
                    end else begin
                        btb_idx_o <= btb_idx_o + BTB_IDX_W'(1);
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    flush_busy_o <= 1'b0;
                    btb_we_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl; expected counters follow BTB_CNT2_EN.
module tb_btb_update_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        upd_valid_i;
    logic        upd_ready_o;
    logic [13:0] upd_pc_i;
    logic [31:0] upd_target_i;
    logic        upd_taken_i;
    logic        flush_req_i;
    logic        flush_busy_o;
    logic [7:0]  ctr_rd_idx_o;
    logic [1:0]  ctr_rd_i;
    logic        btb_we_o;
    logic [7:0]  btb_idx_o;
    logic [3:0]  btb_tag_o;
    logic [31:0] btb_target_o;
    logic        btb_valid_o;
    logic [1:0]  btb_ctr_o;
    logic [2:0]  fifo_cnt_o;

    int total = 0;
    int bad   = 0;

    btb_update_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .upd_valid_i  (upd_valid_i),
        .upd_ready_o  (upd_ready_o),
        .upd_pc_i     (upd_pc_i),
        .upd_target_i (upd_target_i),
        .upd_taken_i  (upd_taken_i),
        .flush_req_i  (flush_req_i),
        .flush_busy_o (flush_busy_o),
        .ctr_rd_idx_o (ctr_rd_idx_o),
        .ctr_rd_i     (ctr_rd_i),
        .btb_we_o     (btb_we_o),
        .btb_idx_o    (btb_idx_o),
        .btb_tag_o    (btb_tag_o),
        .btb_target_o (btb_target_o),
        .btb_valid_o  (btb_valid_o),
        .btb_ctr_o    (btb_ctr_o),
        .fifo_cnt_o   (fifo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Flattened write port: {we, busy, idx, tag, target, valid, ctr}.
    function automatic logic [63:0] wport();
        return {15'd0, btb_we_o, flush_busy_o, btb_idx_o, btb_tag_o, btb_target_o, btb_valid_o, btb_ctr_o};
    endfunction

    function automatic logic [63:0] mk(input logic we, input logic busy, input logic [7:0] idx,
                                       input logic [3:0] tag, input logic [31:0] tgt,
                                       input logic vld, input logic [1:0] ctr);
        return {15'd0, we, busy, idx, tag, tgt, vld, ctr};
    endfunction

`ifdef BTB_CNT2_EN
    localparam logic [1:0] E31   = 2'd2;
    localparam logic [7:0] E32   = {2'd1, 2'd2, 2'd3, 2'd3};
    localparam logic [1:0] E36   = 2'd2;
`else
    localparam logic [1:0] E31   = 2'd3;
    localparam logic [7:0] E32   = {2'd3, 2'd3, 2'd3, 2'd3};
    localparam logic [1:0] E36   = 2'd0;
`endif

    initial begin
        logic [7:0] e32;
        e32 = E32;
        rst_ni       = 1'b0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = '0;
        upd_target_i = '0;
        upd_taken_i  = 1'b0;
        flush_req_i  = 1'b0;
        ctr_rd_i     = 2'd0;

        // Reset state
        #12;
        chk("rst_wport", wport(), 64'd0);
        chk("rst_cnt", fifo_cnt_o, 0);
        chk("rst_rdidx", ctr_rd_idx_o, 0);
        #10 rst_ni = 1'b1;
        tick();
        chk("rst_ready", upd_ready_o, 1);
        chk("rst_idle_we", wport(), 64'd0);

        // Single taken update, ctr_rd_i=1
        upd_valid_i = 1'b1; upd_pc_i = 14'h0124; upd_target_i = 32'h200;
        upd_taken_i = 1'b1; ctr_rd_i = 2'd1;
        tick();
        upd_valid_i = 1'b0;
        chk("single_cnt", fifo_cnt_o, 1);
        chk("single_rdidx", ctr_rd_idx_o, 8'h49);
        chk("single_we_lat1", btb_we_o, 0);
        tick();
        chk("single_write", wport(), mk(1, 0, 8'h49, 4'h0, 32'h200, 1, E31));
        chk("single_cnt0", fifo_cnt_o, 0);
        tick();
        chk("single_we_off", btb_we_o, 0);
        tick();

        // Four back-to-back taken updates to one pc; counter via forwarding
        ctr_rd_i = 2'd0; upd_pc_i = 14'h0C10; upd_target_i = 32'h300; upd_taken_i = 1'b1;
        upd_valid_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("b2b_cnt", fifo_cnt_o, (k <= 4) ? 1 : 0);
            if (k >= 2)
                chk("b2b_write", wport(), mk(1, 0, 8'h04, 4'h3, 32'h300, 1, e32[7-2*(k-2) -: 2]));
            if (k == 4) upd_valid_i = 1'b0;
        end
        tick();
        chk("b2b_we_off", btb_we_o, 0);

        // Not-taken update with ctr_rd_i=3
        upd_valid_i = 1'b1; upd_pc_i = 14'h0008; upd_target_i = 32'h0000_0ABC;
        upd_taken_i = 1'b0; ctr_rd_i = 2'd3;
        tick();
        upd_valid_i = 1'b0;
        tick();
        chk("nt_write", wport(), mk(1, 0, 8'h02, 4'h0, 32'hABC, 1, E36));
        tick();

        // Invalidate while updates are in flight
        ctr_rd_i = 2'd0; upd_taken_i = 1'b1;
        upd_valid_i = 1'b1; upd_pc_i = 14'h0040; upd_target_i = 32'h1000;   // A
        tick();
        upd_pc_i = 14'h0080; upd_target_i = 32'h2000; flush_req_i = 1'b1; // B + request
        tick();
        chk("fl_upd_write", wport(), mk(1, 0, 8'h10, 4'h0, 32'h1000, 1, E36 == 2'd2 ? 2'd1 : 2'd3));
        chk("fl_cnt_b", fifo_cnt_o, 1);
        flush_req_i = 1'b0;
        upd_pc_i = 14'h00C0; upd_target_i = 32'h3000;                        // C, dropped
        tick();
        upd_valid_i = 1'b0;
        chk("fl_first", wport(), mk(1, 1, 8'd0, 4'h0, 32'h0, 0, 2'd0));
        chk("fl_cnt_clr", fifo_cnt_o, 0);
        for (int i = 1; i <= 255; i++) begin
            tick();
            chk("fl_sweep", wport(), mk(1, 1, 8'(i), 4'h0, 32'h0, 0, 2'd0));
            if (i >= 11 && i <= 15) begin
                chk("fl_ready_low", upd_ready_o, 0);
                chk("fl_cnt_hold", fifo_cnt_o, 0);
            end
            upd_valid_i = (i >= 10 && i < 15);
            flush_req_i = (i == 50);
        end
        tick();
        chk("fl_done", wport(), mk(0, 0, 8'hFF, 4'h0, 32'h0, 0, 2'd0));
        chk("fl_done_ready", upd_ready_o, 1);
        chk("fl_done_cnt", fifo_cnt_o, 0);
        tick();
        chk("fl_no_refl", {btb_we_o, flush_busy_o}, 2'b00);

        // Reset in the middle of an invalidate
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        tick();
        chk("rf_start", {btb_we_o, flush_busy_o, btb_idx_o}, {2'b11, 8'd0});
        for (int i = 1; i <= 100; i++) tick();
        chk("rf_idx100", {btb_we_o, btb_idx_o}, {1'b1, 8'd100});
        #2 rst_ni = 1'b0;
        #1;
        chk("rf_abort", wport(), 64'd0);
        #3 rst_ni = 1'b1;
        tick();
        tick();
        chk("rf_idle", {btb_we_o, flush_busy_o, upd_ready_o}, 3'b001);
        tick();
        chk("rf_no_resume", wport(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low (clk_i, rst_ni).
REQ-002 Parameter FIFO_DEPTH, default 4, meaning update-queue depth (power of two, >=2).
REQ-003 clk_i  in  1  clock, all state on rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 upd_valid_i  in  1  EX-stage branch resolved; upd_ready_o  out  1  queue can accept.
REQ-006 upd_pc_i  in  14  branch PC (index = [9:2], tag = [13:10]); upd_target_i  in  32  computed target; upd_taken_i  in  1  resolved outcome.
REQ-007 flush_req_i  in  1  request full BTB invalidate; flush_busy_o  out  1  invalidate in progress.
REQ-008 ctr_rd_idx_o  out  8  counter read index; ctr_rd_i  in  2  BTB counter at ctr_rd_idx_o (combinational read).
REQ-009 btb_we_o  out  1; btb_idx_o  out  8; btb_tag_o  out  4; btb_target_o  out  32; btb_valid_o  out  1; btb_ctr_o  out  2 -- BTB write port, all registered.
REQ-010 fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  queue occupancy.

Function
REQ-011 An update SHALL be pushed when upd_valid_i && upd_ready_o; upd_ready_o = !full && state!=FLUSH.
REQ-012 FSM states SHALL be IDLE, UPDATE, FLUSH; IDLE->UPDATE when queue non-empty and no flush pending; UPDATE->IDLE when queue empties; IDLE/UPDATE->FLUSH on flush pending; FLUSH->IDLE after index 255 written.
REQ-013 In IDLE/UPDATE one head entry SHALL pop per cycle; its write appears on btb_*_o with btb_we_o=1 the following cycle (latency 1 pop-to-write, 2 push-to-write minimum).
REQ-014 ctr_rd_idx_o SHALL equal the head entry index combinationally.
REQ-015 If the head index equals the index of the write currently on btb_*_o with btb_we_o=1, the old counter SHALL be taken from btb_ctr_o, not ctr_rd_i (forwarding).
REQ-016 Each update write SHALL drive valid=1, tag=upd_pc[13:10], target=upd_target, ctr per REQ-027/028.
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged; push when full is impossible (ready low); pop when empty SHALL not occur.
REQ-018 flush_req_i SHALL be latched as pending; flush entry waits only for the current registered write to retire, then has priority over queued updates.
REQ-019 On entering FLUSH the queue SHALL be cleared, including an entry pushed in the same cycle.
REQ-020 In FLUSH, btb_we_o=1 for 256 consecutive cycles, btb_idx_o 0..255, tag/target/valid/ctr all 0.
REQ-021 flush_busy_o SHALL be high from FLUSH entry through the index-255 write cycle; flush_req_i during FLUSH SHALL be ignored.
REQ-022 btb_we_o SHALL be 0 in any cycle with no pop and not in FLUSH.

Reset
REQ-023 Asserting rst_ni SHALL immediately force state IDLE, queue empty, flush pending cleared.
REQ-024 All outputs SHALL reset to 0 except upd_ready_o, which is 1 once rst_ni deasserts.
REQ-025 Reset mid-FLUSH or mid-UPDATE SHALL abort the operation; no automatic flush follows reset.

Configuration
REQ-026 Macro BTB_CNT2_EN selects the counter scheme.
REQ-027 With BTB_CNT2_EN: 2-bit saturating counter, taken -> min(old+1,3), not taken -> max(old-1,0).
REQ-028 Without BTB_CNT2_EN: ctr = taken ? 2'b11 : 2'b00; ctr_rd_i unused and forwarding logic absent.

Structure
REQ-029 Package btb_pkg SHALL hold BTB_ENTRIES=256, BTB_IDX_W=8, BTB_TAG_W=4, the FSM state enum and the update-entry struct (pc, target, taken).
REQ-030 Queue SHALL be a sub-module btb_upd_fifo (synchronous, async reset, count output).

Verification
REQ-031 Single push pc=0x0124 target=0x0000_0200 taken=1, ctr_rd_i=1 (CNT2) -> two cycles later we=1, idx=0x49, tag=0x0, target=0x200, valid=1, ctr=2.
REQ-032 Four back-to-back taken pushes to same pc, ctr_rd_i held 0 -> ctr writes 1,2,3,3 via forwarding.
REQ-033 Push 5 with queue stalled (flush active) -> upd_ready_o low; fifo_cnt_o never exceeds 4.
REQ-034 flush_req_i pulse with 3 queued entries -> at most one update write retires, then 256 writes idx 0..255 all-zero, fifo_cnt_o=0, flush_busy_o low after idx 255.
REQ-035 rst_ni low at FLUSH idx 100 -> btb_we_o=0 immediately, state IDLE, no further flush writes.
REQ-036 Build without BTB_CNT2_EN, not-taken update with ctr_rd_i=3 -> ctr written 0.
